// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty controller: controller FSM states and
// the default duty code range.
package pwm_pkg;

  // Controller FSM states; REPEAT is only reachable when auto-repeat is built.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Default duty code range: 10 steps of 10 %, starting at 50 %.
  localparam int DUTY_MAX  = 10;
  localparam int DUTY_INIT = 5;

endpackage

// File: rtl/pwm_duty_controller_if.sv
// Duty code channel between the duty controller and the PWM generator.
//
// Handshake: duty_valid means a new duty code is pending. The generator raises
// duty_ready at its period boundary; a cycle with duty_valid && duty_ready
// transfers the code and duty_valid drops on the following edge unless a new
// step lands on that same edge. While duty_valid && !duty_ready, duty only
// changes when a new step overwrites the pending code (latest code wins).
interface pwm_duty_controller_if #(
  parameter int DUTY_W = 4
);
  logic [DUTY_W-1:0] duty;
  logic              duty_valid;
  logic              duty_ready;
  logic              at_limit;

  modport master (output duty, output duty_valid, output at_limit, input duty_ready);
  modport slave  (input duty, input duty_valid, input at_limit, output duty_ready);
endinterface

// File: rtl/pwm_button_conditioner.sv
// Raw push-button conditioning: 2-flop synchronizer, counting debouncer and a
// rising-edge pulse on the debounced level. A button already held when reset
// is released never produces a pulse until it has been seen released.
module pwm_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic [1:0]       fill_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q, rise_q;
  logic             differ, settle;

  assign differ = (sync2_q != level_q);
  assign settle = differ && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Synchronizer chain plus a marker telling when sync2_q holds a real sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

  // Debounce: the level follows only after DEBOUNCE_CYCLES differing samples in a row.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      if (!differ || settle) cnt_q <= '0;
      else                   cnt_q <= cnt_q + 1'b1;
      if (settle) level_q <= sync2_q;
      rise_q  <= settle && sync2_q && armed_q;
      armed_q <= armed_q || (fill_q[1] && !sync2_q);
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
endmodule

// File: rtl/pwm_duty_controller.sv
// Push-button duty code controller for a PWM generator.
// Optional feature: define PWM_AUTO_REPEAT_EN to build hold-to-repeat stepping
// (HOLD delay then REPEAT period); otherwise each press gives a single step.
module pwm_duty_controller #(
  parameter int DUTY_W          = 4,
  parameter int DUTY_MAX        = pwm_pkg::DUTY_MAX,
  parameter int DUTY_INIT       = pwm_pkg::DUTY_INIT,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          increment,
  input  logic                          decrement,
  pwm_duty_controller_if.master         bus,
  output pwm_pkg::state_t               dbg_state
);
  localparam logic [DUTY_W:0] MAX_X = (DUTY_W + 1)'(DUTY_MAX);

  logic inc_lvl, inc_rise, dec_lvl, dec_rise;
  logic both_hi, held_lvl;
  logic step_inc, step_dec, changed;

  pwm_pkg::state_t state_q, state_d;
  logic            hold_inc_q, hold_inc_d;
  logic            lock_q, lock_d;
  logic [DUTY_W-1:0] duty_q;
  logic              valid_q;
  logic [DUTY_W:0]   duty_x, duty_nx;

`ifdef PWM_AUTO_REPEAT_EN
  localparam int RMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W = $clog2(RMAX + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // Repeat timing has no effect in the single-step build.
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

  pwm_button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clock(clock), .reset(reset), .button(increment), .level(inc_lvl), .rise(inc_rise)
  );
  pwm_button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clock(clock), .reset(reset), .button(decrement), .level(dec_lvl), .rise(dec_rise)
  );

  assign both_hi  = inc_lvl && dec_lvl;
  assign held_lvl = hold_inc_q ? inc_lvl : dec_lvl;

  // FSM state register plus the lockout that waits for both buttons released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= pwm_pkg::IDLE;
      hold_inc_q <= 1'b0;
      lock_q     <= 1'b0;
`ifdef PWM_AUTO_REPEAT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hold_inc_q <= hold_inc_d;
      lock_q     <= lock_d;
`ifdef PWM_AUTO_REPEAT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Next state and step requests; both buttons high forces IDLE with no step.
  always_comb begin
    state_d    = state_q;
    hold_inc_d = hold_inc_q;
    lock_d     = lock_q;
    step_inc   = 1'b0;
    step_dec   = 1'b0;
`ifdef PWM_AUTO_REPEAT_EN
    cnt_d      = cnt_q;
`endif
    if (both_hi)                 lock_d = 1'b1;
    else if (!inc_lvl && !dec_lvl) lock_d = 1'b0;
    case (state_q)
      pwm_pkg::IDLE: begin
        if (!both_hi && !lock_q && (inc_rise ^ dec_rise)) begin
          step_inc   = inc_rise;
          step_dec   = dec_rise;
          hold_inc_d = inc_rise;
          state_d    = pwm_pkg::HOLD;
`ifdef PWM_AUTO_REPEAT_EN
          cnt_d      = CNT_W'(REPEAT_DELAY);
`endif
        end
      end
      pwm_pkg::HOLD: begin
        if (both_hi || !held_lvl) begin
          state_d = pwm_pkg::IDLE;
        end
`ifdef PWM_AUTO_REPEAT_EN
        else if (cnt_q == CNT_W'(1)) begin
          step_inc = hold_inc_q;
          step_dec = !hold_inc_q;
          cnt_d    = CNT_W'(REPEAT_PERIOD);
          state_d  = pwm_pkg::REPEAT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
`ifdef PWM_AUTO_REPEAT_EN
      pwm_pkg::REPEAT: begin
        if (both_hi || !held_lvl) begin
          state_d = pwm_pkg::IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          step_inc = hold_inc_q;
          step_dec = !hold_inc_q;
          cnt_d    = CNT_W'(REPEAT_PERIOD);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      default: state_d = pwm_pkg::IDLE;
    endcase
  end

  // Saturating duty arithmetic in one extra bit so nothing can wrap.
  always_comb begin
    duty_x  = {1'b0, duty_q};
    duty_nx = duty_x;
    if (step_inc && (duty_x < MAX_X))      duty_nx = duty_x + 1'b1;
    else if (step_dec && (duty_x != '0))   duty_nx = duty_x - 1'b1;
  end

  assign changed = (duty_nx != duty_x);

  // Duty register and pending flag; a fresh step always re-asserts valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      duty_q  <= DUTY_W'(DUTY_INIT);
      valid_q <= 1'b0;
    end else begin
      duty_q  <= duty_nx[DUTY_W-1:0];
      valid_q <= changed || (valid_q && !bus.duty_ready);
    end
  end

  assign bus.duty       = duty_q;
  assign bus.duty_valid = valid_q;
  assign bus.at_limit   = (duty_q == '0) || ({1'b0, duty_q} == MAX_X);
  assign dbg_state      = state_q;
endmodule
